// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, reads the instruction memory
// combinationally and registers each word into a one-entry valid/ready
// stage toward decode. Handles redirects, halt on an all-zero word and a
// sticky fault on a misaligned or out-of-range PC.
//
//   state | meaning
//   RUN   | fetching; one word per cycle when decode keeps up
//   HALT  | stopped on an all-zero word; only a redirect restarts fetch
//   FAULT | illegal PC seen; absorbing until rst
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_inst,
  output logic [31:0] dec_pc,
  output logic        halted,
  output logic        fault,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HALT  = 2'd1,
    FAULT = 2'd2
  } state_t;

  // Upper bound kept at 33 bits so a 4 GiB memory does not wrap to zero.
  localparam logic [32:0] PC_LIMIT = 33'(IMEM_WORDS) * 33'd4;

  state_t      state, state_nxt;
  logic [31:0] pc;
  logic        pc_legal;
  logic        redir;
  logic        fe;
  logic        fe_load;
  logic        fe_zero;
  logic        stall_hold;

  assign imem_addr  = pc;
  assign pc_legal   = (pc[1:0] == 2'b00) && ({1'b0, pc} < PC_LIMIT);
  // Redirects are dropped once faulted.
  assign redir      = redirect_valid && (state != FAULT);
  assign fe         = (state == RUN) && !redirect_valid &&
                      (!dec_valid || dec_ready) && pc_legal;
  assign fe_load    = fe && (imem_inst != 32'h0);
  assign fe_zero    = fe && (imem_inst == 32'h0);
  // Decode is stalled and nothing overrides the held word.
  assign stall_hold = dec_valid && !dec_ready && (state == RUN) &&
                      !redirect_valid && pc_legal;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  // Next-state decode; redirect beats everything outside FAULT.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN: begin
        if (redirect_valid)  state_nxt = RUN;
        else if (!pc_legal)  state_nxt = FAULT;
        else if (fe_zero)    state_nxt = HALT;
      end
      HALT: begin
        if (redirect_valid)  state_nxt = RUN;
      end
      FAULT: state_nxt = FAULT;
      default: state_nxt = FAULT;
    endcase
  end

  // Status outputs follow the state register directly.
  always_comb begin
    halted = (state == HALT);
    fault  = (state == FAULT);
  end

  // Program counter: redirect target, or advance past a presented word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          pc <= RESET_PC;
    else if (redir)   pc <= redirect_pc;
    else if (fe_load) pc <= pc + 32'd4;
  end

  // Decode output stage: load on fetch, hold on stall, otherwise drain/flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dec_valid <= 1'b0;
      dec_inst  <= 32'h0;
      dec_pc    <= 32'h0;
    end else if (fe_load) begin
      dec_valid <= 1'b1;
      dec_inst  <= imem_inst;
      dec_pc    <= pc;
    end else if (!stall_hold) begin
      dec_valid <= 1'b0;
    end
  end

  // Accepted-instruction counter, counts in every state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        fetch_count <= 32'h0;
    else if (dec_valid && dec_ready) fetch_count <= fetch_count + 32'd1;
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a small program in a behavioural imem.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_inst;
  logic [31:0] dec_pc;
  logic        halted;
  logic        fault;
  logic [31:0] fetch_count;

  logic [31:0] mem [0:255];
  int vectors = 0;
  int errors  = 0;

  fetch_ctrl #(.RESET_PC(32'h0), .IMEM_WORDS(256)) dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_inst(imem_inst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_inst(dec_inst), .dec_pc(dec_pc),
    .halted(halted), .fault(fault), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  // Combinational imem; addresses past the array read as zero.
  always_comb begin
    if (imem_addr < 32'h400) imem_inst = mem[imem_addr[9:2]];
    else                     imem_inst = 32'h0;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_dec(input string tag, input logic [31:0] inst,
                         input logic [31:0] pcv, input logic [31:0] cnt);
    chk({tag, ".valid"}, {31'h0, dec_valid}, 32'h1);
    chk({tag, ".inst"},  dec_inst, inst);
    chk({tag, ".pc"},    dec_pc, pcv);
    chk({tag, ".count"}, fetch_count, cnt);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[0] = 32'h002081B3;
    mem[1] = 32'h404182B3;
    mem[2] = 32'h00532023;
    mem[3] = 32'h00032383;

    rst = 1'b1; dec_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
    step();
    chk("rst.valid",  {31'h0, dec_valid}, 32'h0);
    chk("rst.inst",   dec_inst, 32'h0);
    chk("rst.pc",     dec_pc, 32'h0);
    chk("rst.addr",   imem_addr, 32'h0);
    chk("rst.halted", {31'h0, halted}, 32'h0);
    chk("rst.fault",  {31'h0, fault}, 32'h0);
    chk("rst.count",  fetch_count, 32'h0);

    // Straight-line program, one word per cycle, then halt on the zero word.
    rst = 1'b0;
    chk("start.addr", imem_addr, 32'h0);
    step(); chk_dec("seq0", 32'h002081B3, 32'h0, 32'd0);
    step(); chk_dec("seq1", 32'h404182B3, 32'h4, 32'd1);
    step(); chk_dec("seq2", 32'h00532023, 32'h8, 32'd2);
    step(); chk_dec("seq3", 32'h00032383, 32'hC, 32'd3);
    step();
    chk("halt.halted", {31'h0, halted}, 32'h1);
    chk("halt.valid",  {31'h0, dec_valid}, 32'h0);
    chk("halt.addr",   imem_addr, 32'h10);
    chk("halt.count",  fetch_count, 32'd4);
    step();
    chk("halt.stay", {31'h0, halted}, 32'h1);

    // Redirect out of HALT replays the program.
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    step();
    redirect_valid = 1'b0;
    chk("rdh.halted", {31'h0, halted}, 32'h0);
    chk("rdh.valid",  {31'h0, dec_valid}, 32'h0);
    chk("rdh.addr",   imem_addr, 32'h0);
    step(); chk_dec("replay0", 32'h002081B3, 32'h0, 32'd4);
    step(); chk_dec("replay1", 32'h404182B3, 32'h4, 32'd5);

    // Back-pressure for three cycles at dec_pc=0x4.
    dec_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_dec("stall", 32'h404182B3, 32'h4, 32'd5);
      chk("stall.addr", imem_addr, 32'h8);
    end
    dec_ready = 1'b1;
    step(); chk_dec("release", 32'h00532023, 32'h8, 32'd6);

    // Redirect to 0 with a handshake in the same cycle.
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    step();
    redirect_valid = 1'b0;
    chk("rd0.valid", {31'h0, dec_valid}, 32'h0);
    chk("rd0.count", fetch_count, 32'd7);
    step(); chk_dec("rd0.a", 32'h002081B3, 32'h0, 32'd7);
    step(); chk_dec("rd0.b", 32'h404182B3, 32'h4, 32'd8);

    // Redirect at dec_pc=0x4 to 0xC: one bubble, then the target.
    redirect_valid = 1'b1; redirect_pc = 32'hC;
    step();
    redirect_valid = 1'b0;
    chk("rdC.valid", {31'h0, dec_valid}, 32'h0);
    chk("rdC.count", fetch_count, 32'd9);
    chk("rdC.addr",  imem_addr, 32'hC);
    step(); chk_dec("rdC.tgt", 32'h00032383, 32'hC, 32'd9);
    step();
    chk("rdC.halted", {31'h0, halted}, 32'h1);
    chk("rdC.count",  fetch_count, 32'd10);

    // Misaligned redirect faults one edge after the redirect edge.
    redirect_valid = 1'b1; redirect_pc = 32'h6;
    step();
    redirect_valid = 1'b0;
    chk("mis.fault0", {31'h0, fault}, 32'h0);
    chk("mis.halted", {31'h0, halted}, 32'h0);
    step();
    chk("mis.fault1", {31'h0, fault}, 32'h1);
    chk("mis.valid",  {31'h0, dec_valid}, 32'h0);
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    step();
    redirect_valid = 1'b0;
    chk("mis.sticky", {31'h0, fault}, 32'h1);
    chk("mis.valid2", {31'h0, dec_valid}, 32'h0);
    chk("mis.addr",   imem_addr, 32'h6);
    step();
    chk("mis.sticky2", {31'h0, fault}, 32'h1);

    // Reset mid-stream with a stalled valid word.
    rst = 1'b1;
    step();
    rst = 1'b0;
    step(); chk_dec("rs.a", 32'h002081B3, 32'h0, 32'd0);
    step(); chk_dec("rs.b", 32'h404182B3, 32'h4, 32'd1);
    dec_ready = 1'b0;
    step(); chk_dec("rs.stall", 32'h404182B3, 32'h4, 32'd1);
    rst = 1'b1;
    #1;
    chk("arst.valid",  {31'h0, dec_valid}, 32'h0);
    chk("arst.inst",   dec_inst, 32'h0);
    chk("arst.pc",     dec_pc, 32'h0);
    chk("arst.addr",   imem_addr, 32'h0);
    chk("arst.count",  fetch_count, 32'h0);
    chk("arst.fault",  {31'h0, fault}, 32'h0);
    chk("arst.halted", {31'h0, halted}, 32'h0);
    step();
    rst = 1'b0; dec_ready = 1'b1;

    // Last legal word (0x3FC holds zero) halts rather than faults.
    redirect_valid = 1'b1; redirect_pc = 32'h3FC;
    step();
    redirect_valid = 1'b0;
    step();
    chk("edge.halted", {31'h0, halted}, 32'h1);
    chk("edge.fault",  {31'h0, fault}, 32'h0);

    // First out-of-range word faults.
    redirect_valid = 1'b1; redirect_pc = 32'h400;
    step();
    redirect_valid = 1'b0;
    chk("oor.fault0", {31'h0, fault}, 32'h0);
    step();
    chk("oor.fault1", {31'h0, fault}, 32'h1);
    chk("oor.addr",   imem_addr, 32'h400);
    chk("oor.halted", {31'h0, halted}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
